// File: rtl/max_unpool_if.sv
// rtl/max_unpool_if.sv - valid/ready feature stream interface between max_unpool and its neighbours
interface max_unpool_if #(
  parameter int FEATURE_WIDTH = 8,
  parameter int NUM_FEATURES  = 1
);
  logic                                      valid;
  logic                                      ready;
  logic [NUM_FEATURES-1:0][FEATURE_WIDTH-1:0] features;

  modport master (output valid, output features, input ready);
  modport slave  (input valid, input features, output ready);
endinterface

// File: rtl/max_unpool.sv
// rtl/max_unpool.sv - nearest-neighbour upsampler buffering one pooled row at a time
// Optional feature macro: UNPOOL_ZERO_FILL_EN (zero-insertion instead of replication)
module max_unpool #(
  parameter int ROW_STRIDE    = 2,
  parameter int COL_STRIDE    = 2,
  parameter int IMAGE_HEIGHT  = 28,
  parameter int IMAGE_WIDTH   = 28,
  parameter int FEATURE_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  max_unpool_if.slave  features_in,
  max_unpool_if.master features_out,
  output logic        frame_done
);
  localparam int IN_H   = IMAGE_HEIGHT / ROW_STRIDE;
  localparam int IN_W   = IMAGE_WIDTH / COL_STRIDE;
  localparam int COL_W  = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int ROW_W  = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int CREP_W = (COL_STRIDE > 1) ? $clog2(COL_STRIDE) : 1;
  localparam int RREP_W = (ROW_STRIDE > 1) ? $clog2(ROW_STRIDE) : 1;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IN_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IN_H - 1);
  localparam logic [CREP_W-1:0] CREP_LAST = CREP_W'(COL_STRIDE - 1);
  localparam logic [RREP_W-1:0] RREP_LAST = RREP_W'(ROW_STRIDE - 1);

  if (IMAGE_HEIGHT % ROW_STRIDE != 0) begin : g_bad_height
    $fatal(1, "max_unpool: IMAGE_HEIGHT must be a multiple of ROW_STRIDE");
  end
  if (IMAGE_WIDTH % COL_STRIDE != 0) begin : g_bad_width
    $fatal(1, "max_unpool: IMAGE_WIDTH must be a multiple of COL_STRIDE");
  end

  typedef enum logic [1:0] {S_FILL, S_EMIT, S_DONE} state_t;

  state_t              state;
  logic [COL_W-1:0]    in_col;
  logic [ROW_W-1:0]    in_row;
  logic [COL_W-1:0]    out_col;
  logic [CREP_W-1:0]   col_rep;
  logic [RREP_W-1:0]   row_rep;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [FEATURE_WIDTH-1:0] rowbuf [IN_W];

  logic in_fire;
  logic out_fire;

  assign features_in.ready  = in_ready_q;
  assign features_out.valid = out_valid_q;
  assign in_fire  = features_in.valid & in_ready_q;
  assign out_fire = out_valid_q & features_out.ready;

  // Row buffer carries no reset: its contents are always rewritten before being emitted.
  always_ff @(posedge clock) begin
    if (in_fire) begin
      rowbuf[in_col] <= features_in.features[0];
    end
  end

  always_comb begin
    features_out.features = '0;
`ifdef UNPOOL_ZERO_FILL_EN
    if (col_rep == '0 && row_rep == '0) begin
      features_out.features[0] = rowbuf[out_col];
    end
`else
    features_out.features[0] = rowbuf[out_col];
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_FILL;
      in_col      <= '0;
      in_row      <= '0;
      out_col     <= '0;
      col_rep     <= '0;
      row_rep     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      unique case (state)
        S_FILL: begin
          if (in_fire) begin
            if (in_col == COL_LAST) begin
              in_col      <= '0;
              state       <= S_EMIT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              in_col <= in_col + 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (out_fire) begin
            if (col_rep != CREP_LAST) begin
              col_rep <= col_rep + 1'b1;
            end else begin
              col_rep <= '0;
              if (out_col != COL_LAST) begin
                out_col <= out_col + 1'b1;
              end else begin
                out_col <= '0;
                if (row_rep != RREP_LAST) begin
                  row_rep <= row_rep + 1'b1;
                end else begin
                  row_rep     <= '0;
                  out_valid_q <= 1'b0;
                  if (in_row == ROW_LAST) begin
                    in_row     <= '0;
                    state      <= S_DONE;
                    frame_done <= 1'b1;
                  end else begin
                    in_row     <= in_row + 1'b1;
                    state      <= S_FILL;
                    in_ready_q <= 1'b1;
                  end
                end
              end
            end
          end
        end
        S_DONE: begin
          frame_done <= 1'b0;
          in_ready_q <= 1'b1;
          state      <= S_FILL;
        end
        default: begin
          state       <= S_FILL;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          frame_done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_max_unpool.sv
// tb/tb_max_unpool.sv - self-checking bench for max_unpool against a window-replication model
module tb_max_unpool;
  localparam int RS   = 2;
  localparam int CS   = 2;
  localparam int H    = 28;
  localparam int W    = 28;
  localparam int IN_H = H / RS;
  localparam int IN_W = W / CS;
  localparam int FW   = 8;
  localparam int ROW_OUTS = RS * W;
`ifdef UNPOOL_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic frame_done;

  always #5 clock = ~clock;

  max_unpool_if #(.FEATURE_WIDTH(FW)) in_if ();
  max_unpool_if #(.FEATURE_WIDTH(FW)) out_if ();

  max_unpool #(
    .ROW_STRIDE(RS), .COL_STRIDE(CS), .IMAGE_HEIGHT(H), .IMAGE_WIDTH(W), .FEATURE_WIDTH(FW)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .features_in(in_if.slave),
    .features_out(out_if.master),
    .frame_done(frame_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int fd_count = 0;
  int n_out;
  logic [FW-1:0] pix [IN_H*IN_W];
  logic [FW-1:0] got [$];

  typedef struct {
    int            idx;
    logic [FW-1:0] exp;
  } vec_t;
  vec_t table_v [9];

  always @(negedge clock) if (frame_done) fd_count++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output pixel (r,c) comes from pooled pixel (r/RS, c/CS); zero-fill keeps only the window corner.
  function automatic logic [FW-1:0] model(input int r, input int c);
    if (ZF && ((r % RS) != 0 || (c % CS) != 0)) return '0;
    return pix[(r / RS) * IN_W + (c / CS)];
  endfunction

  task automatic do_reset();
    in_if.valid = 1'b0;
    out_if.ready = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic push(input logic [FW-1:0] d, input bit gaps);
    int guard = 0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
    in_if.valid = 1'b1;
    in_if.features[0] = d;
    while (!in_if.ready && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 500) check("push_timeout", 0, 1);
    @(negedge clock);
    in_if.valid = 1'b0;
    in_if.features[0] = $urandom_range(0, 255);
  endtask

  task automatic pop(input int r, input int c, input bit bp);
    int guard = 0;
    while (guard < 500) begin
      out_if.ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (out_if.valid && out_if.ready) break;
      @(negedge clock);
      guard++;
    end
    if (guard >= 500) check("pop_timeout", 0, 1);
    check($sformatf("out(%0d,%0d)", r, c), out_if.features[0], model(r, c));
    check("in_ready_during_emit", in_if.ready, 0);
    got.push_back(out_if.features[0]);
    n_out++;
    @(negedge clock);
    out_if.ready = 1'b0;
  endtask

  task automatic push_row(input int ir, input bit gaps);
    for (int i = 0; i < IN_W; i++) push(pix[ir * IN_W + i], gaps);
  endtask

  task automatic emit_row(input int ir, input bit bp, input int first, input int last);
    for (int k = first; k <= last; k++) pop(ir * RS + k / W, k % W, bp);
  endtask

  task automatic run_frame(input bit bp, input bit ramp);
    int fd0;
    for (int i = 0; i < IN_H * IN_W; i++) pix[i] = ramp ? FW'(i) : FW'($urandom_range(0, 255));
    got.delete();
    n_out = 0;
    fd0 = fd_count;
    for (int ir = 0; ir < IN_H; ir++) begin
      push_row(ir, bp);
      emit_row(ir, bp, 0, ROW_OUTS - 1);
    end
    check("frame_done_pulse", frame_done, 1);
    check("in_ready_in_done", in_if.ready, 0);
    @(negedge clock);
    check("frame_done_once", frame_done, 0);
    check("in_ready_after_done", in_if.ready, 1);
    check("frame_output_count", n_out, H * W);
    #1;
    check("frame_done_pulses", fd_count - fd0, 1);
    check("first_out_first_in", got[0], pix[0]);
  endtask

  initial begin
    in_if.valid = 1'b0;
    in_if.features = '0;
    out_if.ready = 1'b0;
    if (ZF) begin
      table_v = '{'{0, 1}, '{1, 0}, '{2, 2}, '{3, 0}, '{26, 14}, '{27, 0}, '{28, 0}, '{29, 0}, '{55, 0}};
    end else begin
      table_v = '{'{0, 1}, '{1, 1}, '{2, 2}, '{3, 2}, '{26, 14}, '{27, 14}, '{28, 1}, '{29, 1}, '{55, 14}};
    end
    do_reset();
    check("reset_in_ready", in_if.ready, 1);
    check("reset_out_valid", out_if.valid, 0);
    check("reset_frame_done", frame_done, 0);

    // Reset in the middle of filling a row.
    for (int i = 0; i < 5; i++) push(FW'(100 + i), 1'b0);
    do_reset();
    check("midreset_in_ready", in_if.ready, 1);
    check("midreset_out_valid", out_if.valid, 0);
    check("midreset_frame_done", frame_done, 0);

    // Row 0 = 1..14, downstream always ready.
    for (int i = 0; i < IN_W; i++) pix[i] = FW'(i + 1);
    got.delete();
    n_out = 0;
    push_row(0, 1'b0);
    check("first_valid_latency", out_if.valid, 1);
    emit_row(0, 1'b0, 0, ROW_OUTS - 1);
    check("row0_count", got.size(), ROW_OUTS);
    for (int t = 0; t < 9; t++) begin
      check($sformatf("row0_idx%0d", table_v[t].idx), got[table_v[t].idx], table_v[t].exp);
    end
    check("refill_ready", in_if.ready, 1);
    check("refill_valid", out_if.valid, 0);

    // Backpressure at output index 5 for 3 cycles.
    do_reset();
    push_row(0, 1'b0);
    emit_row(0, 1'b0, 0, 4);
    repeat (3) begin
      out_if.ready = 1'b0;
      #1;
      check("bp_valid_held", out_if.valid, 1);
      check("bp_data_held", out_if.features[0], model(0, 5));
      @(negedge clock);
    end
    emit_row(0, 1'b0, 5, ROW_OUTS - 1);

    // Full ramp frame, then a randomized frame with gaps and backpressure.
    do_reset();
    run_frame(1'b0, 1'b1);
    run_frame(1'b1, 1'b0);

    // Reset after 20 outputs of row 3; next frame must start cleanly at pixel (0,0).
    for (int i = 0; i < IN_H * IN_W; i++) pix[i] = FW'($urandom_range(0, 255));
    for (int ir = 0; ir < 3; ir++) begin
      push_row(ir, 1'b1);
      emit_row(ir, 1'b1, 0, ROW_OUTS - 1);
    end
    push_row(3, 1'b1);
    emit_row(3, 1'b1, 0, 19);
    do_reset();
    check("row3_reset_in_ready", in_if.ready, 1);
    check("row3_reset_out_valid", out_if.valid, 0);
    run_frame(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
